// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared encodings and word builder for the node task scheduler
package sched_pkg;

  localparam logic [2:0] OP_IDLE     = 3'b000;
  localparam logic [2:0] OP_DISPATCH = 3'b001;

  localparam int OP_MSB = 5;
  localparam int OP_LSB = 3;
  localparam int ID_MSB = 2;
  localparam int ID_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_OFFER  = 2'd2,
    ST_RUN    = 2'd3
  } sched_state_t;

  // Build the {2'b00, op, id} word handed to the output synchronizer
  function automatic logic [7:0] mk_task(input logic [2:0] op, input logic [2:0] id);
    logic [7:0] w;
    w = 8'h00;
    w[OP_MSB:OP_LSB] = op;
    w[ID_MSB:ID_LSB] = id;
    return w;
  endfunction

endpackage

// File: rtl/sched_rr_pick.sv
// rtl/sched_rr_pick.sv - rotating priority encoder (lowest-index encoder under SCHED_PRIO_EN)
module sched_rr_pick
  import sched_pkg::*;
#(
  parameter int NUM_TASKS = 8
) (
  input  logic [NUM_TASKS-1:0] req,
  input  logic [2:0]           ptr,
  output logic                 hit,
  output logic [2:0]           id
);

`ifdef SCHED_PRIO_EN
  // Fixed priority: the lowest-numbered requester wins, the pointer is ignored
  always_comb begin
    hit = 1'b0;
    id  = 3'd0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        id  = 3'(i);
      end
    end
  end

  logic unused_ptr;
  assign unused_ptr = ^ptr;
`else
  // Round-robin: scan from ptr+1 upward, wrapping past NUM_TASKS-1 to 0
  always_comb begin
    hit = 1'b0;
    id  = 3'd0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      int idx;
      idx = (int'(ptr) + 1 + i) % NUM_TASKS;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        id  = 3'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/node_task_scheduler.sv
// rtl/node_task_scheduler.sv - per-node task scheduler; SCHED_PRIO_EN selects fixed priority with preemption
module node_task_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_TASKS = 8,
  parameter int QUANTUM   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_TASKS-1:0] task_ready_set,
  input  logic [NUM_TASKS-1:0] task_wait_set,
  input  logic                 task_yield,
  input  logic                 next_ack,
  output logic [7:0]           next_task,
  output logic                 next_valid,
  output logic [NUM_TASKS-1:0] task_state,
  output logic [2:0]           cur_task_id
);

  localparam int QW = $clog2(QUANTUM + 1);
  localparam logic [2:0] PTR_RESET = 3'(NUM_TASKS - 1);

  sched_state_t   state_q, state_d;
  logic [2:0]     rr_ptr, ptr_d;
  logic [QW-1:0]  cnt, cnt_d;
  logic [7:0]     task_d;
  logic           valid_d;
  logic [2:0]     cur_d;
  logic           pick_hit;
  logic [2:0]     pick_id;
  logic           cur_ready;
  logic           preempt;

  sched_rr_pick #(.NUM_TASKS(NUM_TASKS)) u_pick (
    .req (task_state),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .id  (pick_id)
  );

  // Ready/wait bits: a wait pulse beats a ready pulse on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) task_state <= '0;
    else        task_state <= (task_state | task_ready_set) & ~task_wait_set;
  end

  // State bit of the task currently offered or running
  always_comb begin
    cur_ready = 1'b0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (3'(i) == cur_task_id) cur_ready = task_state[i];
    end
  end

`ifdef SCHED_PRIO_EN
  // A lower-numbered ready task preempts the running one
  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (3'(i) < cur_task_id) preempt = preempt | task_state[i];
    end
  end
`else
  assign preempt = 1'b0;
`endif

  // Scheduler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr      <= PTR_RESET;
      cnt         <= '0;
      next_task   <= 8'h00;
      next_valid  <= 1'b0;
      cur_task_id <= 3'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr      <= ptr_d;
      cnt         <= cnt_d;
      next_task   <= task_d;
      next_valid  <= valid_d;
      cur_task_id <= cur_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    ptr_d   = rr_ptr;
    cnt_d   = cnt;
    task_d  = next_task;
    valid_d = next_valid;
    cur_d   = cur_task_id;
    if (!enable) begin
      state_d = ST_IDLE;
      task_d  = mk_task(OP_IDLE, 3'd0);
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          task_d  = mk_task(OP_IDLE, 3'd0);
          valid_d = 1'b0;
          if (|task_state) state_d = ST_SELECT;
        end
        ST_SELECT: begin
          if (pick_hit) begin
            task_d  = mk_task(OP_DISPATCH, pick_id);
            valid_d = 1'b1;
            cur_d   = pick_id;
            ptr_d   = pick_id;
            state_d = ST_OFFER;
          end else begin
            task_d  = mk_task(OP_IDLE, 3'd0);
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        ST_OFFER: begin
          // An ack in the same cycle as a withdrawal still commits the dispatch
          if (next_ack) begin
            valid_d = 1'b0;
            cnt_d   = QW'(QUANTUM - 1);
            state_d = ST_RUN;
          end else if (!cur_ready) begin
            valid_d = 1'b0;
            state_d = ST_SELECT;
          end
        end
        ST_RUN: begin
          if (cnt == '0 || task_yield || !cur_ready || preempt) state_d = ST_SELECT;
          else                                                  cnt_d   = cnt - QW'(1);
        end
        default: begin
          state_d = ST_IDLE;
          task_d  = mk_task(OP_IDLE, 3'd0);
          valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_task_scheduler.sv
// tb/tb_node_task_scheduler.sv - directed self-checking bench for node_task_scheduler
module tb_node_task_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] task_ready_set;
  logic [7:0] task_wait_set;
  logic       task_yield;
  logic       next_ack;
  logic [7:0] next_task;
  logic       next_valid;
  logic [7:0] task_state;
  logic [2:0] cur_task_id;

  int errors = 0;
  int checks = 0;

  node_task_scheduler #(.NUM_TASKS(8), .QUANTUM(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .task_ready_set (task_ready_set),
    .task_wait_set  (task_wait_set),
    .task_yield     (task_yield),
    .next_ack       (next_ack),
    .next_task      (next_task),
    .next_valid     (next_valid),
    .task_state     (task_state),
    .cur_task_id    (cur_task_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready(input logic [7:0] m);
    task_ready_set = m;
    tick();
    task_ready_set = 8'h00;
  endtask

  task automatic do_ack();
    next_ack = 1'b1;
    tick();
    next_ack = 1'b0;
  endtask

  task automatic do_yield();
    task_yield = 1'b1;
    tick();
    task_yield = 1'b0;
  endtask

  // Bounded wait for an offer, then compare the offered word and id
  task automatic expect_offer(input string tag, input logic [2:0] id);
    for (int i = 0; i < 40 && !next_valid; i++) tick();
    check({tag, "_valid"}, 32'(next_valid), 32'd1);
    check({tag, "_word"}, 32'(next_task), 32'({5'b00001, id}));
    check({tag, "_cur"}, 32'(cur_task_id), 32'(id));
  endtask

  logic [2:0] rr_seq [4];

  initial begin
    rst_n = 1'b0; enable = 1'b0; task_ready_set = 8'h00; task_wait_set = 8'h00;
    task_yield = 1'b0; next_ack = 1'b0;
    tick(); tick();
    check("rst_task", 32'(next_task), 32'h00);
    check("rst_valid", 32'(next_valid), 32'd0);
    check("rst_state", 32'(task_state), 32'h00);
    check("rst_cur", 32'(cur_task_id), 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    tick();

    // Latency: ready pulse at E0, offer visible after E2
    pulse_ready(8'h04);
    check("lat_e0_state", 32'(task_state), 32'h04);
    check("lat_e0_valid", 32'(next_valid), 32'd0);
    tick();
    check("lat_e1_valid", 32'(next_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(next_valid), 32'd1);
    check("lat_e2_word", 32'(next_task), 32'h0A);
    tick();
    check("offer_hold", 32'(next_task), 32'h0A);
    do_ack();
    check("ack_valid", 32'(next_valid), 32'd0);
    check("run_word", 32'(next_task), 32'h0A);
    for (int i = 0; i < 16; i++) tick();
    check("q_expire_valid", 32'(next_valid), 32'd0);
    tick();
    check("q_reoffer_valid", 32'(next_valid), 32'd1);
    check("q_reoffer_word", 32'(next_task), 32'h0A);

    // Withdraw during offer; same-cycle ready/wait on task 4
    task_wait_set = 8'h14; task_ready_set = 8'h10;
    tick();
    task_wait_set = 8'h00; task_ready_set = 8'h00;
    check("wd_state", 32'(task_state), 32'h00);
    tick();
    check("wd_valid", 32'(next_valid), 32'd0);
    tick();
    check("wd_idle_word", 32'(next_task), 32'h00);

    // Reset while task 3 runs
    pulse_ready(8'h08);
    expect_offer("t3", 3'd3);
    do_ack();
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_task", 32'(next_task), 32'h00);
    check("mid_rst_valid", 32'(next_valid), 32'd0);
    check("mid_rst_state", 32'(task_state), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Tasks 1,5,6 ready, ack each offer then yield
`ifdef SCHED_PRIO_EN
    rr_seq = '{3'd1, 3'd1, 3'd1, 3'd1};
`else
    rr_seq = '{3'd1, 3'd5, 3'd6, 3'd1};
`endif
    pulse_ready(8'h62);
    for (int k = 0; k < 4; k++) begin
      expect_offer($sformatf("rr%0d", k), rr_seq[k]);
      do_ack();
      if (k < 3) do_yield();
    end

    // Drop enable during RUN, re-enable resumes after rr_ptr
    tick();
    enable = 1'b0;
    tick();
    check("dis_word", 32'(next_task), 32'h00);
    check("dis_valid", 32'(next_valid), 32'd0);
    enable = 1'b1;
`ifdef SCHED_PRIO_EN
    expect_offer("reen", 3'd1);
`else
    expect_offer("reen", 3'd5);
`endif
    do_ack();

    // Clear everything, let the FSM fall back to IDLE
    task_wait_set = 8'hFF;
    tick();
    task_wait_set = 8'h00;
    tick(); tick(); tick();
    check("clr_valid", 32'(next_valid), 32'd0);
    check("clr_word", 32'(next_task), 32'h00);

    // Task 0 runs, task 7 becomes ready, yield on slice cycle 3
    pulse_ready(8'h01);
    expect_offer("t0", 3'd0);
    do_ack();
    pulse_ready(8'h80);
    tick();
    do_yield();
    check("yld_sel_valid", 32'(next_valid), 32'd0);
    tick();
    check("yld_valid", 32'(next_valid), 32'd1);
`ifdef SCHED_PRIO_EN
    check("yld_word", 32'(next_task), 32'h08);
    check("yld_cur", 32'(cur_task_id), 32'd0);
`else
    check("yld_word", 32'(next_task), 32'h0F);
    check("yld_cur", 32'(cur_task_id), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_task_scheduler.md
Name: node_task_scheduler

Overview:
- Per-node task scheduler that produces the 8-bit next_task word consumed by the node output synchronizer.
- Keeps a ready/wait state bit per task and picks ready tasks round-robin.
- Offers each pick through a valid/ack handshake, then holds it for a time-slice quantum.
- Word format is {2'b00, op[5:3], task_id[2:0]}, where op = 000 IDLE and 001 DISPATCH.

Parameters:
- NUM_TASKS, 8, number of schedulable tasks; legal range 1..8 because the id field is 3 bits.
- QUANTUM, 16, time slice in clk cycles; legal range 2..65535.
- QW, $clog2(QUANTUM+1), quantum counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable; low forces IDLE
- task_ready_set  in  NUM_TASKS  one-cycle pulses; set task state to ready (1)
- task_wait_set  in  NUM_TASKS  one-cycle pulses; set task state to wait (0)
- task_yield  in  1  pulse; the running task ends its slice early
- next_ack  in  1  downstream has latched the offered dispatch
- next_task  out  8  scheduled word {2'b00, op, id}
- next_valid  out  1  dispatch offer pending
- task_state  out  NUM_TASKS  registered ready(1)/wait(0) bits
- cur_task_id  out  3  id of the last dispatched task

Behaviour:
- Reset (async, rst_n=0), all registered:
  - task_state=0, next_task=8'h00, next_valid=0, cur_task_id=0.
  - rr_ptr=NUM_TASKS-1, so the first search starts at id 0.
  - Quantum counter=0, FSM=IDLE.
  - Release of reset is synchronous to clk.
- task_state update, every edge:
  - bit <= (bit | ready_set) & ~wait_set.
  - If ready_set and wait_set hit the same bit in the same cycle, wait wins.
  - Bits at or above NUM_TASKS are absent.
- FSM is evaluated on the registered task_state.
- IDLE:
  - next_task=8'h00, next_valid=0.
  - If enable=1 and any task_state bit is set, go to SELECT.
- SELECT (one cycle):
  - Rotating search from rr_ptr+1 with wrap at NUM_TASKS-1 back to 0.
  - On a hit: next_task <= {2'b00, 3'b001, id}, next_valid <= 1, cur_task_id <= id, rr_ptr <= id, go to OFFER.
  - No hit: go to IDLE.
- OFFER:
  - Hold next_task and next_valid stable until next_ack.
  - On next_ack: next_valid <= 0, counter <= QUANTUM-1, go to RUN.
  - If the offered task's state drops to 0 while waiting: next_valid <= 0, go to SELECT (offer withdrawn).
- RUN:
  - next_task stays at the dispatch word; the counter decrements each cycle.
  - Go to SELECT when any of these holds: counter==0, task_yield=1, or the current task's state is 0.
  - If the running task is still the only ready task, it is re-dispatched.
- enable=0 in any state: next edge goes to IDLE with next_task=8'h00 and next_valid=0. rr_ptr is preserved.
- next_ack outside OFFER is ignored.
- Latency from IDLE: a task_ready_set pulse sampled at edge E0 gives next_valid=1 after edge E2.
- From RUN expiry (counter==0 at edge E0), the new offer is visible after E1+1 edge (SELECT takes one cycle).
- Counter arithmetic is unsigned QW bits; it never underflows (exit happens at 0).

Optional Feature:
- Macro: SCHED_PRIO_EN.
- Defined: fixed priority. SELECT picks the lowest-numbered ready task and ignores rr_ptr (rr_ptr is still updated).
  - A higher-priority task becoming ready during RUN preempts at the next edge: RUN goes to SELECT.
- Undefined: round-robin as described above, with no preemption except on wait/yield/quantum expiry.

Decomposition:
- Package sched_pkg:
  - OP_IDLE=3'b000, OP_DISPATCH=3'b001.
  - Field positions OP_MSB=5, OP_LSB=3, ID_MSB=2, ID_LSB=0.
  - FSM state encoding: IDLE, SELECT, OFFER, RUN.
  - Word builder function mk_task(op, id).
- Sub-module sched_rr_pick:
  - Combinational rotating priority encoder.
  - Inputs: req[NUM_TASKS-1:0], ptr[2:0]. Outputs: hit, id[2:0].
  - Under SCHED_PRIO_EN it acts as a plain lowest-index encoder.

Test Plan:
- Reset mid-RUN (rst_n low for 1 cycle while task 3 is running) -> next_task=8'h00, next_valid=0, task_state=0 immediately, before the next clk edge.
- enable=1, ready_set=8'b0000_0100 at E0 -> next_valid=1 and next_task=8'h0A after E2; ack -> RUN.
  - Exactly 16 cycles later, with no ack and a single task, the same 8'h0A is re-offered.
- Tasks 1, 5, 6 ready; ack every offer -> dispatch ids 1, 5, 6, 1 (round-robin wrap) with SCHED_PRIO_EN undefined; with it defined -> 1, 1, 1.
- Task 2 offered, wait_set[2] during OFFER with no ack -> next_valid drops the next cycle and the FSM returns to IDLE (no other task ready). The same-cycle ready_set[4] and wait_set[4] leaves task_state[4]=0.
- Task 0 in RUN, task_yield at cycle 3 of the slice, task 7 ready -> next_task=8'h0F offered 2 cycles later, cur_task_id=7.
- enable dropped during RUN -> next_task=8'h00 the next cycle. Re-enable -> search resumes from rr_ptr+1.
